crop_bbox_detect: RTL and testbench
===================================

Name: crop_bbox_detect

Overview:
Parametrised successor to the single-edge crop-start detector. Scans a raster pixel stream and finds the bounding box of "object" pixels inside a programmable search window: min/max X and min/max Y. Adds threshold classification, a minimum-hit validity check, frame resync and a one-cycle frame-done strobe. Sits between the capture/greyscale path and the crop/scaler stage; the crop stage consumes the box once per frame.

Parameters:
H_ACTIVE, 640, active pixels per line
V_ACTIVE, 480, active lines per frame
DATA_W, 10, pixel data width
CNT_W, 16, width of coordinate counters, box outputs and hit counter
WIN_X0, 161, first X column of search window (inclusive)
WIN_X1, 479, last X column of search window (inclusive)
WIN_Y0, 121, first Y line of search window (inclusive)
WIN_Y1, 189, last Y line of search window (inclusive)
THRESH, 0, pixel is a hit when iDATA <= THRESH (unsigned)
MIN_HITS, 1, minimum hits per frame for a valid box

Ports:
iCLK  in  1  clock
iRST  in  1  reset, asynchronous, active-low
iDVAL  in  1  pixel valid; one pixel accepted per cycle when high
iDATA  in  DATA_W  pixel value
iSOF  in  1  frame resync; clears position and accumulators
oXSTART  out  CNT_W  leftmost hit column of last valid frame
oXEND  out  CNT_W  rightmost hit column of last valid frame
oYSTART  out  CNT_W  first hit line of last valid frame
oYEND  out  CNT_W  last hit line of last valid frame
oHITS  out  CNT_W  hit count of last completed frame (saturating)
oVALID  out  1  last completed frame reached MIN_HITS
oDONE  out  1  one-cycle pulse at frame completion

Behaviour:
- Reset: all outputs 0; X/Y counters 0; accumulators at sentinels (min = all ones, max = 0, hits = 0).
- Position: X_Cont/Y_Cont address the pixel currently on iDATA. On accepted pixel X increments; at X = H_ACTIVE-1 wraps to 0 and Y increments; at (H_ACTIVE-1, V_ACTIVE-1) both wrap to 0 (frame end). No advance when iDVAL low.
- Hit = iDVAL and WIN_X0<=X<=WIN_X1 and WIN_Y0<=Y<=WIN_Y1 and iDATA<=THRESH.
- Per hit: minX = min(minX,X); maxX = max(maxX,X); if first hit of frame then minY = Y; maxY = Y (Y monotonic, so last hit row); hits += 1, saturating at 2^CNT_W-1.
- Frame end: the last pixel's own hit is included. One cycle after it is accepted: oDONE = 1 for exactly one cycle; oHITS = final hits; oVALID = (hits >= MIN_HITS); if valid, oXSTART/oXEND/oYSTART/oYEND load minX/maxX/minY/maxY, else box outputs hold previous values. Accumulators return to sentinels the same cycle, so the next frame's first pixel may arrive back-to-back.
- Outputs hold stable between oDONE pulses.
- iSOF high (any cycle, iDVAL irrelevant): X/Y = 0, accumulators to sentinels, partial frame discarded, no oDONE, outputs unchanged. A pixel with iDVAL in the same cycle is dropped; the next accepted pixel is (0,0).
- iSOF in the same cycle as a frame-end pixel: iSOF wins; no oDONE.
- Async reset mid-frame: immediate return to reset state; partial frame lost.
- All comparisons unsigned at CNT_W; parameters must satisfy WIN_X0<=WIN_X1<H_ACTIVE and WIN_Y0<=WIN_Y1<V_ACTIVE, with H_ACTIVE, V_ACTIVE < 2^CNT_W.

Test Plan:
- Reset then all-white frame (iDATA=1023, iDVAL continuous) -> oDONE pulses once at cycle 307200+1, oHITS=0, oVALID=0, box outputs stay 0.
- Dark rectangle X 200..300, Y 130..150 (iDATA=0), rest 1023 -> oXSTART=200, oXEND=300, oYSTART=130, oYEND=150, oHITS=2121, oVALID=1.
- Dark pixels at X=160, X=480, Y=120 and Y=190 only (window edges outside) -> oHITS=0, oVALID=0; pixels at (161,121) and (479,189) only -> box 161/479/121/189, oHITS=2.
- Frame 1 box as scenario 2, frame 2 all-white with MIN_HITS=1 -> frame 2 oVALID=0, oHITS=0, box outputs still 200/300/130/150.
- Half frame of dark pixels, then iSOF pulse, then a full frame with a single dark pixel at (250,160) -> exactly one oDONE, box 250/250/160/160, oHITS=1.
- iDVAL toggled 1-of-3 cycles with scenario-2 image; plus iRST pulse mid-frame followed by full frame -> same results as scenario 2; after reset, outputs 0 until next oDONE.

Source files
------------

// File: rtl/crop_bbox_detect.sv
// Raster bounding-box detector: tracks min/max X/Y of thresholded pixels inside a
// fixed search window and publishes the box once per frame with a done strobe.
module crop_bbox_detect #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int DATA_W   = 10,
  parameter int CNT_W    = 16,
  parameter int WIN_X0   = 161,
  parameter int WIN_X1   = 479,
  parameter int WIN_Y0   = 121,
  parameter int WIN_Y1   = 189,
  parameter int THRESH   = 0,
  parameter int MIN_HITS = 1
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iDVAL,
  input  logic [DATA_W-1:0] iDATA,
  input  logic              iSOF,
  output logic [CNT_W-1:0]  oXSTART,
  output logic [CNT_W-1:0]  oXEND,
  output logic [CNT_W-1:0]  oYSTART,
  output logic [CNT_W-1:0]  oYEND,
  output logic [CNT_W-1:0]  oHITS,
  output logic              oVALID,
  output logic              oDONE
);

  localparam logic [CNT_W-1:0]  X_LAST = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0]  Y_LAST = CNT_W'(V_ACTIVE - 1);
  localparam logic [CNT_W-1:0]  WX0    = CNT_W'(WIN_X0);
  localparam logic [CNT_W-1:0]  WX1    = CNT_W'(WIN_X1);
  localparam logic [CNT_W-1:0]  WY0    = CNT_W'(WIN_Y0);
  localparam logic [CNT_W-1:0]  WY1    = CNT_W'(WIN_Y1);
  localparam logic [CNT_W-1:0]  MINH   = CNT_W'(MIN_HITS);
  localparam logic [DATA_W-1:0] TH     = DATA_W'(THRESH);

  logic [CNT_W-1:0] r_x, r_y;
  logic [CNT_W-1:0] r_minx, r_maxx, r_miny, r_maxy, r_hits;
  logic [CNT_W-1:0] r_xs, r_xe, r_ys, r_ye, r_hits_o;
  logic             r_valid_o, r_done;

  logic             w_acc, w_hit, w_eof, w_x_last;
  logic [CNT_W-1:0] w_minx_n, w_maxx_n, w_miny_n, w_maxy_n, w_hits_n;
  logic             w_valid_n;

  // iSOF overrides any pixel presented in the same cycle
  assign w_acc    = iDVAL && !iSOF;
  assign w_x_last = (r_x == X_LAST);
  assign w_eof    = w_acc && w_x_last && (r_y == Y_LAST);
  assign w_hit    = w_acc && (r_x >= WX0) && (r_x <= WX1) &&
                    (r_y >= WY0) && (r_y <= WY1) && (iDATA <= TH);

  // Accumulator values including the current pixel, so the frame-end pixel counts
  always_comb begin
    w_minx_n = r_minx;
    w_maxx_n = r_maxx;
    w_miny_n = r_miny;
    w_maxy_n = r_maxy;
    w_hits_n = r_hits;
    if (w_hit) begin
      if (r_x < r_minx) w_minx_n = r_x;
      if (r_x > r_maxx) w_maxx_n = r_x;
      // hits saturates, never wraps to 0, so zero marks "no hit yet this frame"
      if (r_hits == '0) w_miny_n = r_y;
      w_maxy_n = r_y;
      if (r_hits != '1) w_hits_n = r_hits + 1'b1;
    end
  end

  assign w_valid_n = (w_hits_n >= MINH);

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_x       <= '0;
      r_y       <= '0;
      r_minx    <= '1;
      r_maxx    <= '0;
      r_miny    <= '1;
      r_maxy    <= '0;
      r_hits    <= '0;
      r_xs      <= '0;
      r_xe      <= '0;
      r_ys      <= '0;
      r_ye      <= '0;
      r_hits_o  <= '0;
      r_valid_o <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (iSOF || w_eof) begin
        r_x    <= '0;
        r_y    <= '0;
        r_minx <= '1;
        r_maxx <= '0;
        r_miny <= '1;
        r_maxy <= '0;
        r_hits <= '0;
        if (!iSOF) begin
          r_done    <= 1'b1;
          r_hits_o  <= w_hits_n;
          r_valid_o <= w_valid_n;
          if (w_valid_n) begin
            r_xs <= w_minx_n;
            r_xe <= w_maxx_n;
            r_ys <= w_miny_n;
            r_ye <= w_maxy_n;
          end
        end
      end else if (iDVAL) begin
        r_minx <= w_minx_n;
        r_maxx <= w_maxx_n;
        r_miny <= w_miny_n;
        r_maxy <= w_maxy_n;
        r_hits <= w_hits_n;
        if (w_x_last) begin
          r_x <= '0;
          r_y <= r_y + 1'b1;
        end else begin
          r_x <= r_x + 1'b1;
        end
      end
    end
  end

  assign oXSTART = r_xs;
  assign oXEND   = r_xe;
  assign oYSTART = r_ys;
  assign oYEND   = r_ye;
  assign oHITS   = r_hits_o;
  assign oVALID  = r_valid_o;
  assign oDONE   = r_done;

endmodule

// File: tb/tb_crop_bbox_detect.sv
// Scoreboard bench for crop_bbox_detect on a reduced raster; a frame-level model
// computes the expected box from the stored image.
module tb_crop_bbox_detect;
  localparam int H = 64, V = 48, DW = 10, CW = 16;
  localparam int X0 = 10, X1 = 40, Y0 = 8, Y1 = 30, TH = 3, MH = 2;

  typedef struct packed {
    logic [CW-1:0] xs, xe, ys, ye, hits;
    logic          valid;
  } res_t;

  logic          iCLK = 1'b0, iRST = 1'b0, iDVAL = 1'b0, iSOF = 1'b0;
  logic [DW-1:0] iDATA = '0;
  logic [CW-1:0] oXSTART, oXEND, oYSTART, oYEND, oHITS;
  logic          oVALID, oDONE;

  crop_bbox_detect #(
    .H_ACTIVE(H), .V_ACTIVE(V), .DATA_W(DW), .CNT_W(CW),
    .WIN_X0(X0), .WIN_X1(X1), .WIN_Y0(Y0), .WIN_Y1(Y1),
    .THRESH(TH), .MIN_HITS(MH)
  ) dut (
    .iCLK(iCLK), .iRST(iRST), .iDVAL(iDVAL), .iDATA(iDATA), .iSOF(iSOF),
    .oXSTART(oXSTART), .oXEND(oXEND), .oYSTART(oYSTART), .oYEND(oYEND),
    .oHITS(oHITS), .oVALID(oVALID), .oDONE(oDONE)
  );

  always #5 iCLK = ~iCLK;

  logic [DW-1:0] img [V][H];
  res_t q[$];
  res_t held;    // box published by the last valid frame
  int   n_checks = 0, n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic res_t dut_res();
    res_t r;
    r.xs = oXSTART; r.xe = oXEND; r.ys = oYSTART; r.ye = oYEND;
    r.hits = oHITS; r.valid = oVALID;
    return r;
  endfunction

  task automatic cmp_res(input string tag, input res_t a, input res_t e);
    chk({tag, "_xs"}, int'(a.xs), int'(e.xs));
    chk({tag, "_xe"}, int'(a.xe), int'(e.xe));
    chk({tag, "_ys"}, int'(a.ys), int'(e.ys));
    chk({tag, "_ye"}, int'(a.ye), int'(e.ye));
    chk({tag, "_hits"}, int'(a.hits), int'(e.hits));
    chk({tag, "_valid"}, int'(a.valid), int'(e.valid));
  endtask

  // Reference: scan the stored image for in-window pixels at or below threshold
  function automatic res_t model();
    res_t r;
    int   hits = 0, mnx = H, mxx = -1, mny = V, mxy = -1;
    for (int y = Y0; y <= Y1; y++)
      for (int x = X0; x <= X1; x++)
        if (img[y][x] <= TH) begin
          hits++;
          mnx = (x < mnx) ? x : mnx;
          mxx = (x > mxx) ? x : mxx;
          mny = (y < mny) ? y : mny;
          mxy = (y > mxy) ? y : mxy;
        end
    r = held;
    r.hits  = CW'(hits);
    r.valid = (hits >= MH);
    if (r.valid) begin
      r.xs = CW'(mnx); r.xe = CW'(mxx); r.ys = CW'(mny); r.ye = CW'(mxy);
    end
    held = r;
    return r;
  endfunction

  task automatic fill(input int v);
    for (int y = 0; y < V; y++) for (int x = 0; x < H; x++) img[y][x] = DW'(v);
  endtask

  task automatic rect(input int xa, input int xb, input int ya, input int yb);
    fill(1023);
    for (int y = ya; y <= yb; y++) for (int x = xa; x <= xb; x++) img[y][x] = '0;
  endtask

  // mode 0: full frame; 1: iSOF at pixel cut; 2: async reset at pixel cut
  task automatic send_frame(input bit gaps, input int mode, input int cut);
    for (int p = 0; p < H * V; p++) begin
      if (mode != 0 && p == cut) begin
        @(negedge iCLK);
        if (mode == 1) begin
          iSOF = 1'b1; iDVAL = 1'b1; iDATA = '0;
        end else begin
          iDVAL = 1'b0;
          #2 iRST = 1'b0;
          #1 cmp_res("rst_mid", dut_res(), '0);
          chk("rst_mid_done", int'(oDONE), 0);
          held = '0;
          @(negedge iCLK) iRST = 1'b1;
        end
        return;
      end
      if (gaps) repeat (2) begin
        @(negedge iCLK);
        iSOF = 1'b0; iDVAL = 1'b0; iDATA = DW'($urandom_range(0, 1023));
      end
      if (p == H * V - 1) q.push_back(model());
      @(negedge iCLK);
      iSOF = 1'b0; iDVAL = 1'b1; iDATA = img[p / H][p % H];
    end
    @(negedge iCLK);
    iDVAL = 1'b0; iSOF = 1'b0;
  endtask

  // Monitor: pops on every done pulse, otherwise outputs must hold
  res_t cur = '0;
  initial forever begin
    @(posedge iCLK);
    #1;
    if (!iRST) cur = '0;
    else if (oDONE) begin
      if (q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        cur = q.pop_front();
        cmp_res("frame", dut_res(), cur);
      end
    end else if (dut_res() != cur) begin
      cmp_res("hold", dut_res(), cur);
    end else begin
      n_checks++; n_pass++;
    end
  end

  initial begin
    held = '0;
    repeat (3) @(negedge iCLK);
    cmp_res("reset", dut_res(), '0);
    chk("reset_done", int'(oDONE), 0);
    iRST = 1'b1;

    fill(1023);                send_frame(0, 0, 0);  // all white
    rect(15, 30, 12, 20);      send_frame(0, 0, 0);  // 144 hits
    fill(1023);                                      // window edges from outside + threshold edge
    img[15][X0-1] = '0; img[15][X1+1] = '0; img[Y0-1][20] = '0; img[Y1+1][20] = '0;
    img[20][20] = DW'(TH + 1);
    send_frame(0, 0, 0);
    fill(1023); img[Y0][X0] = DW'(TH); img[Y1][X1] = '0;
    send_frame(0, 0, 0);                             // corners inside
    rect(15, 30, 12, 20);      send_frame(0, 0, 0);
    fill(1023);                send_frame(0, 0, 0);  // invalid, box held
    rect(X0, X1, Y0, Y1);      send_frame(0, 1, H * V / 2);
    fill(1023); img[16][25] = '0;
    send_frame(0, 0, 0);                             // one hit, below MIN_HITS
    img[18][26] = '0;          send_frame(0, 0, 0);
    rect(12, 35, 9, 25);       send_frame(0, 1, H * V - 1); // iSOF on last pixel
    rect(15, 30, 12, 20);      send_frame(1, 0, 0);  // 1-of-3 valid
    rect(11, 20, 10, 28);      send_frame(0, 2, H * V / 2);
    repeat (3) @(negedge iCLK);
    rect(15, 30, 12, 20);      send_frame(0, 0, 0);
    for (int f = 0; f < 4; f++) begin
      int dens = (f == 0) ? 4000 : 200;
      for (int y = 0; y < V; y++) for (int x = 0; x < H; x++)
        img[y][x] = ($urandom_range(0, 9999) < dens) ? DW'($urandom_range(0, TH + 1))
                                                     : DW'($urandom_range(TH + 1, 1023));
      send_frame(f[0], 0, 0);
    end
    repeat (5) @(negedge iCLK);
    chk("pending_done", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
